wchan_rr_arbiter: RTL and testbench

//  Shares one TX_channel write-data path between N requesters at packet granularity.

---
 rtl/wchan_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_wchan_rr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wchan_rr_arbiter.sv
// Packet-granular round-robin arbiter sharing one TX_channel write-data path between N requesters.
// Define ARB_WATCHDOG_EN to release a grant whose owner stalls for TIMEOUT cycles.
module wchan_rr_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  parameter int TIMEOUT   = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_last,
  output logic [$clog2(N)-1:0] m_src,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] gnt;
  logic [IDX_W-1:0] gnt_inc;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  int               cand_idx;
  logic [CNT_W-1:0] beat_cnt;
  logic [WIDTH-1:0] beat_data;
  logic             beat_last;
  logic             out_free;
  logic             xfer;
  logic             release_gnt;
  logic             wd_fire;

  // Scan from the far end back toward rr_ptr so the nearest requester wins.
  always_comb begin
    winner   = '0;
    cand     = '0;
    cand_idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_idx = (int'(rr_ptr) + k) % N;
      cand     = IDX_W'(cand_idx);
      if (req_valid[cand]) winner = cand;
    end
  end

  assign gnt_inc   = (gnt == IDX_W'(N - 1)) ? '0 : gnt + 1'b1;
  assign beat_data = req_data[gnt*WIDTH +: WIDTH];
  assign beat_last = req_last[gnt] || (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign out_free  = !m_valid || m_ready;

`ifdef ARB_WATCHDOG_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] stall_cnt;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      stall_cnt <= '0;
    end else if (state != LOCK || req_valid[gnt] || wd_fire) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    next_state  = state;
    req_ready   = '0;
    xfer        = 1'b0;
    release_gnt = 1'b0;
    wd_fire     = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) next_state = LOCK;
      end
      LOCK: begin
        req_ready[gnt] = out_free;
        xfer           = req_valid[gnt] && out_free;
`ifdef ARB_WATCHDOG_EN
        wd_fire        = !req_valid[gnt] && (stall_cnt == STALL_W'(TIMEOUT - 1));
`endif
        release_gnt    = (xfer && beat_last) || wd_fire;
        if (release_gnt) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= next_state;
  end

  // Grant, pointer and beat counter
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      if (state == IDLE && |req_valid) gnt <= winner;
      if (release_gnt) begin
        rr_ptr   <= gnt_inc;
        beat_cnt <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Output register stage: hold under backpressure, replace on same-cycle drain + transfer
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_src   <= '0;
    end else if (xfer) begin
      m_valid <= 1'b1;
      m_data  <= beat_data;
      m_last  <= beat_last;
      m_src   <= gnt;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  assign busy        = (state == LOCK) || m_valid;
  assign err_timeout = wd_fire;

endmodule

// File: tb/tb_wchan_rr_arbiter.sv
// Self-checking bench for wchan_rr_arbiter: table-driven packet vectors with an output scoreboard,
// plus hand-written sequences for backpressure, forced last, async reset and the watchdog.
module tb_wchan_rr_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic [1:0]  m_src;
  logic        m_ready;
  logic        busy;
  logic        err_timeout;

  wchan_rr_arbiter dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_src       (m_src),
    .m_ready     (m_ready),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [3:0]  mask;
    int          beats;
    int          extra0;
    logic [7:0]  rdy;
    logic [31:0] order;
    int          norder;
    int          span;
  } vec_t;

  vec_t        vecs[6];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          first_acc;
  int          last_acc;
  logic [8:0]  src_q[4][$];
  logic [10:0] exp_q[$];
  logic [7:0]  rdy_pat;
  logic        err_seen;

  function automatic logic [7:0] dat(input int s, input int p, input int b);
    logic [31:0] sv, pv, bv;
    sv = s; pv = p; bv = b;
    return {sv[1:0], pv[1:0], bv[3:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive from source queues, check the output handshake, retire accepted beats.
  task automatic step();
    logic [3:0]  acc;
    logic [8:0]  b;
    logic [10:0] e;
    logic [31:0] c;
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        b = src_q[i][0];
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = b[7:0];
        req_last[i]        = b[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    c = cyc;
    m_ready = rdy_pat[c[2:0]];
    #1;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_beat: got src=%0d last=%0b data=0x%0h, expected no beat", m_src, m_last, m_data);
      end else begin
        e = exp_q.pop_front();
        check("out_beat {src,last,data}", 32'({m_src, m_last, m_data}), 32'(e));
      end
    end
    check("req_ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
    err_seen = err_timeout;
    acc = req_valid & req_ready;
    @(posedge ACLK);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        void'(src_q[i].pop_front());
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
    end
    @(negedge ACLK);
  endtask

  task automatic do_reset();
    ARESETn   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    m_ready   = 1'b0;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    exp_q.delete();
    rdy_pat   = 8'hFF;
    first_acc = -1;
    last_acc  = -1;
    @(negedge ACLK);
    @(negedge ACLK);
    check("reset_state", 32'({m_valid, m_data, m_last, m_src, req_ready, busy, err_timeout}), 32'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check({name, "_beats_outstanding"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int          pk[4];
    int          npk;
    int          s;
    int          c0;
    int          err_cnt;
    int          err_at;
    logic [31:0] ord;

    //               mask     beats extra0 rdy           order       n  span
    vecs[0] = '{4'b0110, 3,  0, 8'hFF,       32'h21,     2, 6};
    vecs[1] = '{4'b1111, 1,  1, 8'hFF,       32'h03210,  5, 8};
    vecs[2] = '{4'b1001, 2,  0, 8'b10110110, 32'h30,     2, -1};
    vecs[3] = '{4'b1111, 2,  0, 8'b11011101, 32'h3210,   4, -1};
    vecs[4] = '{4'b1000, 4,  0, 8'hFF,       32'h3,      1, 3};
    vecs[5] = '{4'b1010, 16, 0, 8'hF7,       32'h31,     2, -1};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      rdy_pat = vecs[v].rdy;
      for (int i = 0; i < 4; i++) begin
        pk[i] = 0;
        if (vecs[v].mask[i]) begin
          npk = (i == 0) ? 1 + vecs[v].extra0 : 1;
          for (int p = 0; p < npk; p++)
            for (int b = 0; b < vecs[v].beats; b++)
              src_q[i].push_back({(b == vecs[v].beats - 1), dat(i, p, b)});
        end
      end
      ord = vecs[v].order;
      for (int k = 0; k < vecs[v].norder; k++) begin
        s = int'(ord[4*k +: 4]);
        for (int b = 0; b < vecs[v].beats; b++)
          exp_q.push_back({2'(s), (b == vecs[v].beats - 1), dat(s, pk[s], b)});
        pk[s]++;
      end
      drain($sformatf("vec%0d", v), 300);
      if (vecs[v].span >= 0)
        check($sformatf("vec%0d_accept_span", v), 32'(last_acc - first_acc), 32'(vecs[v].span));
      check($sformatf("vec%0d_sources_empty", v),
            32'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 32'd0);
    end

    // Backpressure mid-packet: A5 must stay on m_data and req0 must not be accepted.
    do_reset();
    src_q[0].push_back({1'b0, 8'hA5});
    src_q[0].push_back({1'b1, 8'h3C});
    exp_q.push_back({2'd0, 1'b0, 8'hA5});
    exp_q.push_back({2'd0, 1'b1, 8'h3C});
    c0 = cyc;
    step();
    check("lat_m_valid_after_grant", 32'(m_valid), 32'd0);
    step();
    check("lat_first_accept_edge", 32'(first_acc - c0), 32'd2);
    check("lat_m_valid_after_capture", 32'(m_valid), 32'd1);
    rdy_pat = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold {m_valid,m_data}", 32'({m_valid, m_data}), 32'h1A5);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rdy_pat = 8'hFF;
    drain("stall", 20);
    check("stall_no_beat_lost", 32'(src_q[0].size()), 32'd0);

    // Forced last at beat 16; pending req1 goes next, then req0's remaining beats.
    do_reset();
    for (int b = 0; b < 20; b++) src_q[0].push_back({1'b0, 8'(8'h40 + b)});
    src_q[1].push_back({1'b0, 8'h90});
    src_q[1].push_back({1'b1, 8'h91});
    for (int b = 0; b < 16; b++) exp_q.push_back({2'd0, (b == 15), 8'(8'h40 + b)});
    exp_q.push_back({2'd1, 1'b0, 8'h90});
    exp_q.push_back({2'd1, 1'b1, 8'h91});
    for (int b = 16; b < 20; b++) exp_q.push_back({2'd0, 1'b0, 8'(8'h40 + b)});
    drain("forced_last", 100);
    check("forced_last_src0_empty", 32'(src_q[0].size()), 32'd0);

    // Async reset mid-packet with gnt=2 and rr_ptr=2; afterwards req0 must win.
    do_reset();
    src_q[1].push_back({1'b1, 8'h11});
    exp_q.push_back({2'd1, 1'b1, 8'h11});
    drain("pre_reset", 20);
    src_q[2].push_back({1'b0, 8'h21});
    src_q[2].push_back({1'b0, 8'h22});
    src_q[2].push_back({1'b1, 8'h23});
    step();
    step();
    check("pre_reset_m_valid", 32'(m_valid), 32'd1);
    ARESETn = 1'b0;
    #1;
    check("async_reset_m_valid", 32'(m_valid), 32'd0);
    check("async_reset_req_ready", 32'(req_ready), 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    do_reset();
    src_q[0].push_back({1'b1, 8'h05});
    src_q[2].push_back({1'b1, 8'h25});
    exp_q.push_back({2'd0, 1'b1, 8'h05});
    exp_q.push_back({2'd2, 1'b1, 8'h25});
    drain("post_reset", 30);

    // gnt=2 sends one beat then stalls while req3 waits.
    do_reset();
    src_q[2].push_back({1'b0, 8'h2A});
    src_q[3].push_back({1'b1, 8'h3B});
    exp_q.push_back({2'd2, 1'b0, 8'h2A});
`ifdef ARB_WATCHDOG_EN
    exp_q.push_back({2'd3, 1'b1, 8'h3B});
`endif
    step();
    step();
    err_cnt = 0;
    err_at  = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (err_seen) begin
        err_cnt++;
        if (err_at < 0) err_at = k;
      end
    end
    check("wd_beats_outstanding", 32'(exp_q.size()), 32'd0);
`ifdef ARB_WATCHDOG_EN
    check("wd_err_pulse_count", 32'(err_cnt), 32'd1);
    check("wd_err_pulse_cycle", 32'(err_at), 32'd32);
    check("wd_req3_served", 32'(src_q[3].size()), 32'd0);
`else
    check("no_wd_err_pulse_count", 32'(err_cnt), 32'd0);
    check("no_wd_req3_waiting", 32'(src_q[3].size()), 32'd1);
    check("no_wd_busy_held", 32'(busy), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running at %0t, expected completion", $time);
    $fatal(1, "time limit");
  end

endmodule
